// File: rtl/seq_detect_param.sv
// Parametrised serial sequence detector: compares the last PATTERN_LEN samples of x
// against a reloadable pattern register, pulses z on a match and counts matches.
module seq_detect_param #(
    parameter int                     PATTERN_LEN = 4,
    parameter logic [PATTERN_LEN-1:0] PATTERN     = 4'b1100,
    parameter bit                     OVERLAP     = 1'b1,
    parameter int                     CNT_WIDTH   = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   x,
    input  logic                   load_pattern,
    input  logic [PATTERN_LEN-1:0] pattern_in,
    output logic                   z,
    output logic [CNT_WIDTH-1:0]   match_count
);

    localparam int                FILL_W   = $clog2(PATTERN_LEN);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PATTERN_LEN - 1);

    logic [PATTERN_LEN-1:0] pat_reg;
    logic [PATTERN_LEN-2:0] hist;
    logic [FILL_W-1:0]      fill;

    logic [PATTERN_LEN-1:0] win;
    logic                   match;
    logic [CNT_WIDTH-1:0]   cnt_inc;
    logic [FILL_W-1:0]      fill_next;

    always_comb begin
        win     = {hist, x};
        // fill guards against matching stale zeros before a full window is seen
        match   = (fill == FILL_MAX) && (win == pat_reg);
        cnt_inc = (&match_count) ? match_count : match_count + CNT_WIDTH'(1);
        if (match && !OVERLAP)
            fill_next = '0;
        else if (fill == FILL_MAX)
            fill_next = FILL_MAX;
        else
            fill_next = fill + FILL_W'(1);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pat_reg     <= PATTERN;
            hist        <= '0;
            fill        <= '0;
            z           <= 1'b0;
            match_count <= '0;
        end else if (load_pattern) begin
            pat_reg     <= pattern_in;
            hist        <= '0;
            fill        <= '0;
            z           <= 1'b0;
            match_count <= '0;
        end else if (enable) begin
            hist        <= win[PATTERN_LEN-2:0];
            fill        <= fill_next;
            z           <= match;
            match_count <= match ? cnt_inc : match_count;
        end else begin
            z           <= 1'b0;
        end
    end

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench for seq_detect_param: three instances (overlap, non-overlap,
// 2-bit counter) share the same stimulus; expected values are hand-computed.
module tb_seq_detect_param;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       x = 1'b0;
    logic       load_pattern = 1'b0;
    logic [3:0] pattern_in = 4'b0000;

    logic       z_ov, z_no, z_sat;
    logic [7:0] cnt_ov, cnt_no;
    logic [1:0] cnt_sat;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    seq_detect_param #(.PATTERN_LEN(4), .PATTERN(4'b1100), .OVERLAP(1'b1), .CNT_WIDTH(8)) dut_ov (
        .clock(clock), .reset(reset), .enable(enable), .x(x), .load_pattern(load_pattern),
        .pattern_in(pattern_in), .z(z_ov), .match_count(cnt_ov));

    seq_detect_param #(.PATTERN_LEN(4), .PATTERN(4'b1100), .OVERLAP(1'b0), .CNT_WIDTH(8)) dut_no (
        .clock(clock), .reset(reset), .enable(enable), .x(x), .load_pattern(load_pattern),
        .pattern_in(pattern_in), .z(z_no), .match_count(cnt_no));

    seq_detect_param #(.PATTERN_LEN(4), .PATTERN(4'b1100), .OVERLAP(1'b1), .CNT_WIDTH(2)) dut_sat (
        .clock(clock), .reset(reset), .enable(enable), .x(x), .load_pattern(load_pattern),
        .pattern_in(pattern_in), .z(z_sat), .match_count(cnt_sat));

    // Drive one cycle of inputs, then sample #1 after the rising edge.
    task automatic step(input logic xv, input logic en);
        x      = xv;
        enable = en;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(1'($urandom), 1'b1);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step(1'($urandom), 1'b1);
            n_checks++;
            if ({z_ov, z_no, z_sat} !== 3'b000 || cnt_ov !== 8'd0 || cnt_no !== 8'd0 || cnt_sat !== 2'd0) begin
                n_fail++;
                $display("FAIL reset edge %0d: z=%b%b%b counts=%0d/%0d/%0d, want z=000 counts=0",
                         i, z_ov, z_no, z_sat, cnt_ov, cnt_no, cnt_sat);
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_default_stream();
        logic [14:0] stream;
        logic [14:0] zexp;
        stream = 15'b111001110011001;
        zexp   = 15'b000010000100010;
        do_reset();
        for (int i = 0; i < 15; i++) begin
            step(stream[14-i], 1'b1);
            n_checks++;
            if (z_ov !== zexp[14-i]) begin
                n_fail++;
                $display("FAIL default_stream bit %0d: z=%b want %b", i + 1, z_ov, zexp[14-i]);
            end
        end
        n_checks++;
        if (cnt_ov !== 8'd3) begin
            n_fail++;
            $display("FAIL default_stream count: got %0d want 3", cnt_ov);
        end
    endtask

    task automatic test_overlap();
        logic [5:0] stream;
        logic [5:0] zov_exp;
        logic [5:0] zno_exp;
        stream  = 6'b101010;
        zov_exp = 6'b000101;
        zno_exp = 6'b000100;
        do_reset();
        load_pattern = 1'b1;
        pattern_in   = 4'b1010;
        step(1'b1, 1'b1);
        load_pattern = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step(stream[5-i], 1'b1);
            n_checks++;
            if (z_ov !== zov_exp[5-i] || z_no !== zno_exp[5-i]) begin
                n_fail++;
                $display("FAIL overlap bit %0d: z_ov=%b z_no=%b want %b %b",
                         i + 1, z_ov, z_no, zov_exp[5-i], zno_exp[5-i]);
            end
        end
        n_checks++;
        if (cnt_ov !== 8'd2 || cnt_no !== 8'd1) begin
            n_fail++;
            $display("FAIL overlap counts: got %0d/%0d want 2/1", cnt_ov, cnt_no);
        end
    endtask

    task automatic test_runtime_load();
        logic [6:0] pre;
        logic [4:0] post;
        pre  = 7'b1100011;
        post = 5'b10111;
        do_reset();
        for (int i = 0; i < 7; i++) step(pre[6-i], 1'b1);
        n_checks++;
        if (cnt_ov !== 8'd1) begin
            n_fail++;
            $display("FAIL load pre-count: got %0d want 1", cnt_ov);
        end
        // History now ends in 011: an uncleared window would match 0111 on the next 1.
        load_pattern = 1'b1;
        pattern_in   = 4'b0111;
        step(1'b1, 1'b1);
        load_pattern = 1'b0;
        n_checks++;
        if (z_ov !== 1'b0 || cnt_ov !== 8'd0) begin
            n_fail++;
            $display("FAIL load cycle: z=%b count=%0d want 0 0", z_ov, cnt_ov);
        end
        for (int i = 0; i < 5; i++) begin
            step(post[4-i], 1'b1);
            n_checks++;
            if (z_ov !== (i == 4)) begin
                n_fail++;
                $display("FAIL load post bit %0d: z=%b want %b", i, z_ov, (i == 4));
            end
        end
        n_checks++;
        if (cnt_ov !== 8'd1) begin
            n_fail++;
            $display("FAIL load post-count: got %0d want 1", cnt_ov);
        end
    endtask

    task automatic test_enable_gaps();
        logic [3:0] pat;
        pat = 4'b1100;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(pat[3-i], 1'b1);
            n_checks++;
            if (z_ov !== (i == 3)) begin
                n_fail++;
                $display("FAIL gaps enabled sample %0d: z=%b want %b", i + 1, z_ov, (i == 3));
            end
            for (int g = 0; g < 2; g++) begin
                step(~pat[3-i], 1'b0);
                n_checks++;
                if (z_ov !== 1'b0) begin
                    n_fail++;
                    $display("FAIL gaps idle after sample %0d: z=%b want 0", i + 1, z_ov);
                end
            end
        end
        n_checks++;
        if (cnt_ov !== 8'd1) begin
            n_fail++;
            $display("FAIL gaps count: got %0d want 1", cnt_ov);
        end
    endtask

    task automatic test_saturation();
        logic [3:0] pat;
        logic [1:0] sat_exp;
        pat = 4'b1100;
        do_reset();
        for (int m = 1; m <= 5; m++) begin
            for (int i = 0; i < 4; i++) step(pat[3-i], 1'b1);
            sat_exp = (m >= 3) ? 2'd3 : 2'(m);
            n_checks++;
            if (z_sat !== 1'b1 || cnt_sat !== sat_exp) begin
                n_fail++;
                $display("FAIL saturation match %0d: z=%b count=%0d want 1 %0d", m, z_sat, cnt_sat, sat_exp);
            end
        end
        n_checks++;
        if (cnt_ov !== 8'd5 || cnt_no !== 8'd5) begin
            n_fail++;
            $display("FAIL saturation wide counts: got %0d/%0d want 5/5", cnt_ov, cnt_no);
        end
    endtask

    task automatic test_midmatch_reset();
        do_reset();
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        reset = 1'b1;
        step(1'b0, 1'b1);
        reset = 1'b0;
        n_checks++;
        if ({z_ov, z_no, z_sat} !== 3'b000) begin
            n_fail++;
            $display("FAIL midreset reset cycle: z=%b%b%b want 000", z_ov, z_no, z_sat);
        end
        step(1'b0, 1'b1);
        n_checks++;
        if ({z_ov, z_no, z_sat} !== 3'b000 || cnt_ov !== 8'd0) begin
            n_fail++;
            $display("FAIL midreset after: z=%b%b%b count=%0d want 000 0", z_ov, z_no, z_sat, cnt_ov);
        end
    endtask

    initial begin
        test_reset();
        test_default_stream();
        test_overlap();
        test_runtime_load();
        test_enable_gaps();
        test_saturation();
        test_midmatch_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
